alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters. Requester 0 is the core datapath and requester 1 is the address/auxiliary unit. Each requester sends operands and a 4-bit ALU control code through a valid/ready request channel. The block drives the shared ALU for the granted requester and registers `out`/`zero` into a per-requester response slot, which is returned through a valid/ready response channel.

## Interface
- `W`, default 32: operand/result width (ALU is fixed at 32; kept for clarity).
- `IDLE_CTRL`, default 4'b1111: control code driven to the ALU when no grant (an unused code, so ALU `out` = 0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `r0_req_valid` / `r1_req_valid`  in  1  request present.
- `r0_req_ready` / `r1_req_ready`  out  1  request accepted this cycle (combinational grant).
- `r0_in1`, `r0_in2` / `r1_in1`, `r1_in2`  in  W  operands (signed).
- `r0_shamt` / `r1_shamt`  in  5  shift amount.
- `r0_ctrl` / `r1_ctrl`  in  4  ALU op: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, SLT 0111, SRL 1000. Any other code gives result 0.
- `r0_rsp_valid` / `r1_rsp_valid`  out  1  response slot full.
- `r0_rsp_ready` / `r1_rsp_ready`  in  1  requester takes the response.
- `r0_rsp_out` / `r1_rsp_out`  out  W  registered ALU result.
- `r0_rsp_zero` / `r1_rsp_zero`  out  1  registered ALU zero flag.
- `alu_in1`, `alu_in2`  out  W  to the shared ALU.
- `alu_shamt`  out  5  to the shared ALU.
- `alu_ctrl`  out  4  to the shared ALU.
- `alu_out`  in  W  from the shared ALU (combinational, same cycle).
- `alu_zero`  in  1  from the shared ALU (combinational, same cycle).
- `gnt`  out  2  one-hot current grant; 00 when idle.

## Operation
- Eligibility: requester i is eligible when `ri_req_valid` is 1 and the slot is free or draining this cycle (`!ri_rsp_valid || ri_rsp_ready`).
- Grant: at most one requester per cycle.
  - One eligible requester: it is granted.
  - Both eligible: grant the requester opposite to `last_grant`.
  - `last_grant` updates only on a transfer.
- `ri_req_ready` = `gnt[i]`. A transfer occurs when `ri_req_valid && ri_req_ready`.
- ALU drive:
  - Granted: `alu_*` carry the granted requester's `in1`, `in2`, `shamt`, `ctrl`.
  - Idle: `in1`, `in2`, `shamt` = 0 and `ctrl` = `IDLE_CTRL`.
- ALU semantics, for the verifier's model:
  - ADD and SUB wrap modulo 2^32.
  - SLT is a signed compare, result 0 or 1.
  - SLL is `in2 << shamt`.
  - SRL is an arithmetic right shift of `in2`.
  - `zero` = (`out` == 0).
- Response update on transfer edge: `ri_rsp_out` ← `alu_out`, `ri_rsp_zero` ← `alu_zero`, `ri_rsp_valid` ← 1.
- Response drain: if the slot drains (`rsp_valid && rsp_ready`) with no new transfer, `rsp_valid` ← 0 and the data holds its last value.
- Drain and transfer in the same cycle: `rsp_valid` stays 1 and the data is replaced (back-to-back throughput).
- Request fields are sampled only in the cycle `req_ready` = 1. Requesters keep the request asserted until accepted.

## Timing
- Reset values:
  - `rsp_valid`, `rsp_out`, `rsp_zero` = 0 for both requesters.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - `gnt` = 00 and both `req_ready` = 0 while `rst` is high.
  - ALU is driven idle while `rst` is high.
- Latency: request accepted in cycle N produces `rsp_valid` = 1 in cycle N+1.
- Throughput:
  - One ALU op per cycle in total.
  - A lone requester with `rsp_ready` held high sustains 1 op/cycle.
  - Two contending requesters alternate, each getting 1 op per 2 cycles.
- Backpressure: a full slot with `rsp_ready` = 0 blocks that requester only. The other requester may take every cycle.
- No starvation: a requester that stays eligible is granted within 2 cycles.
- Reset mid-operation discards held responses and grant history. No response from before reset appears after it.
- No combinational path from `rsp_out`/`rsp_zero` to `req_ready`. `req_ready` depends on `req_valid`, `rsp_valid`, `rsp_ready` and `last_grant` only.

## Test plan
- Single op: r0 ADD, in1 = 5, in2 = 7, `rsp_ready` = 1 → `r0_req_ready` = 1 in cycle N. In cycle N+1, `r0_rsp_valid` = 1, `r0_rsp_out` = 12, `r0_rsp_zero` = 0.
- Contention after reset: both requesters valid every cycle, r0 SUB 9−9, r1 SLT −1 vs 1 →
  - grants r0, r1, r0, r1 …
  - r0 results are 0 with zero = 1.
  - r1 results are 1 with zero = 0.
- Backpressure: r1 requests SRL `in2` = 0x80000000, `shamt` = 4 while `r1_rsp_ready` = 0 →
  - first response 0xF8000000 is held.
  - `r1_req_ready` stays 0 while r0 ADDs keep being granted every cycle.
  - raising `r1_rsp_ready` gives a drain and a new grant in the same cycle.
- Back-to-back: r0 issues SLL `in2` = 1 with `shamt` = 0..31 on consecutive cycles, `rsp_ready` = 1 → 32 responses on consecutive cycles, values 1, 2, 4 … 0x80000000, no gaps.
- Illegal code: r0 `ctrl` = 1100, in1 = 3, in2 = 4 → `rsp_out` = 0, `rsp_zero` = 1.
- Reset mid-flight: assert `rst` for 1 cycle while both slots are full →
  - next cycle: all `rsp_valid` = 0, `rsp_out` = 0, `gnt` = 00.
  - first contention after reset grants r0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response/ALU bundle between two requesters, the arbiter and the shared ALU
//
// Purpose: groups every handshake and bus signal of alu_arbiter so the block
//          takes a single bus port next to its plain clk/rst.
// Signals (per requester i = 0, 1):
//   ri_req_valid / ri_req_ready            request channel handshake
//   ri_in1, ri_in2, ri_shamt, ri_ctrl      request payload (operands, shift amount, ALU op)
//   ri_rsp_valid / ri_rsp_ready            response channel handshake
//   ri_rsp_out, ri_rsp_zero                registered ALU result and zero flag
// Shared ALU side:
//   alu_in1, alu_in2, alu_shamt, alu_ctrl  operands/op driven to the ALU
//   alu_out, alu_zero                      combinational ALU result
//   gnt                                    one-hot current grant, 00 when idle
// Modports: slave = the arbiter, master = requesters plus the ALU.

interface alu_arbiter_if #(
    parameter int W = 32
);
    logic         r0_req_valid;
    logic         r0_req_ready;
    logic [W-1:0] r0_in1;
    logic [W-1:0] r0_in2;
    logic [4:0]   r0_shamt;
    logic [3:0]   r0_ctrl;
    logic         r0_rsp_valid;
    logic         r0_rsp_ready;
    logic [W-1:0] r0_rsp_out;
    logic         r0_rsp_zero;

    logic         r1_req_valid;
    logic         r1_req_ready;
    logic [W-1:0] r1_in1;
    logic [W-1:0] r1_in2;
    logic [4:0]   r1_shamt;
    logic [3:0]   r1_ctrl;
    logic         r1_rsp_valid;
    logic         r1_rsp_ready;
    logic [W-1:0] r1_rsp_out;
    logic         r1_rsp_zero;

    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [4:0]   alu_shamt;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_out;
    logic         alu_zero;

    logic [1:0]   gnt;

    modport slave (
        input  r0_req_valid, r0_in1, r0_in2, r0_shamt, r0_ctrl, r0_rsp_ready,
        output r0_req_ready, r0_rsp_valid, r0_rsp_out, r0_rsp_zero,
        input  r1_req_valid, r1_in1, r1_in2, r1_shamt, r1_ctrl, r1_rsp_ready,
        output r1_req_ready, r1_rsp_valid, r1_rsp_out, r1_rsp_zero,
        output alu_in1, alu_in2, alu_shamt, alu_ctrl,
        input  alu_out, alu_zero,
        output gnt
    );

    modport master (
        output r0_req_valid, r0_in1, r0_in2, r0_shamt, r0_ctrl, r0_rsp_ready,
        input  r0_req_ready, r0_rsp_valid, r0_rsp_out, r0_rsp_zero,
        output r1_req_valid, r1_in1, r1_in2, r1_shamt, r1_ctrl, r1_rsp_ready,
        input  r1_req_ready, r1_rsp_valid, r1_rsp_out, r1_rsp_zero,
        input  alu_in1, alu_in2, alu_shamt, alu_ctrl,
        output alu_out, alu_zero,
        input  gnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 32-bit ALU between two requesters
//
// Purpose: each cycle grants at most one eligible requester, steers its
//          operands to the shared ALU and captures the ALU result into that
//          requester's single-entry response slot on the same edge.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   alu_arbiter_if.slave: both request/response channels, ALU drive,
//         ALU result and the one-hot grant
// Parameters:
//   W          operand/result width
//   IDLE_CTRL  op code driven to the ALU when nobody is granted (unused code -> out 0)

module alu_arbiter #(
    parameter int         W         = 32,
    parameter logic [3:0] IDLE_CTRL = 4'b1111
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    logic         r0_valid_q;
    logic [W-1:0] r0_out_q;
    logic         r0_zero_q;
    logic         r1_valid_q;
    logic [W-1:0] r1_out_q;
    logic         r1_zero_q;

    // Index of the requester that completed the most recent transfer.
    // Resets to 1 so requester 0 wins the first contention.
    logic         last_grant;

    logic         elig0;
    logic         elig1;
    logic [1:0]   gnt;

    // Grant logic looks only at request valid, slot state, rsp_ready and
    // last_grant, so there is no path from response data to req_ready.
    always_comb begin
        elig0 = bus.r0_req_valid && (!r0_valid_q || bus.r0_rsp_ready);
        elig1 = bus.r1_req_valid && (!r1_valid_q || bus.r1_rsp_ready);
        gnt   = 2'b00;
        if (!rst) begin
            if (elig0 && elig1) begin
                gnt = last_grant ? 2'b01 : 2'b10;
            end else if (elig0) begin
                gnt = 2'b01;
            end else if (elig1) begin
                gnt = 2'b10;
            end
        end
    end

    // ALU operand steering; zeros plus the idle code when nobody is granted.
    always_comb begin
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        bus.alu_shamt = 5'd0;
        bus.alu_ctrl  = IDLE_CTRL;
        if (gnt[0]) begin
            bus.alu_in1   = bus.r0_in1;
            bus.alu_in2   = bus.r0_in2;
            bus.alu_shamt = bus.r0_shamt;
            bus.alu_ctrl  = bus.r0_ctrl;
        end else if (gnt[1]) begin
            bus.alu_in1   = bus.r1_in1;
            bus.alu_in2   = bus.r1_in2;
            bus.alu_shamt = bus.r1_shamt;
            bus.alu_ctrl  = bus.r1_ctrl;
        end
    end

    // A grant is only ever given to a valid requester, so gnt[i] is the
    // transfer strobe. A transfer wins over a drain in the same cycle,
    // which keeps the slot full and gives back-to-back throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_valid_q <= 1'b0;
            r0_out_q   <= '0;
            r0_zero_q  <= 1'b0;
            r1_valid_q <= 1'b0;
            r1_out_q   <= '0;
            r1_zero_q  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (gnt[0]) begin
                r0_valid_q <= 1'b1;
                r0_out_q   <= bus.alu_out;
                r0_zero_q  <= bus.alu_zero;
                last_grant <= 1'b0;
            end else if (r0_valid_q && bus.r0_rsp_ready) begin
                r0_valid_q <= 1'b0;
            end

            if (gnt[1]) begin
                r1_valid_q <= 1'b1;
                r1_out_q   <= bus.alu_out;
                r1_zero_q  <= bus.alu_zero;
                last_grant <= 1'b1;
            end else if (r1_valid_q && bus.r1_rsp_ready) begin
                r1_valid_q <= 1'b0;
            end
        end
    end

    assign bus.gnt          = gnt;
    assign bus.r0_req_ready = gnt[0];
    assign bus.r1_req_ready = gnt[1];
    assign bus.r0_rsp_valid = r0_valid_q;
    assign bus.r0_rsp_out   = r0_out_q;
    assign bus.r0_rsp_zero  = r0_zero_q;
    assign bus.r1_rsp_valid = r1_valid_q;
    assign bus.r1_rsp_out   = r1_out_q;
    assign bus.r1_rsp_zero  = r1_zero_q;

endmodule
